systolic_mm_engine: RTL

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

---
 rtl/systolic_mm_engine_pkg.sv | 20 ++
 rtl/systolic_mm_engine_pe_mac.sv | 34 +++
 rtl/systolic_mm_engine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_mm_engine_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic matrix engine.
package systolic_mm_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  // Cycles needed for the last beat to reach the far corner PE of a size x size array.
  function automatic int unsigned drain_len(input int unsigned size);
    return 2 * size - 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_pe_mac.sv
// One processing element: multiply-accumulate with registered a/b forwarding.
module pe_mac #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] prod;

  assign prod = PW'(a_in) * PW'(b_in);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary SIZE x SIZE systolic engine computing C = A x B for runtime N <= SIZE.
module systolic_mm_engine
  import systolic_mm_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(SIZE+1)-1:0]    n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0]   a_col_line,
  input  logic [SIZE*DATA_WIDTH-1:0]   b_row_line,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         c_data,
  output logic [idx_w(SIZE)-1:0]       c_row,
  output logic [idx_w(SIZE)-1:0]       c_col,
  output logic                         c_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned NW        = $clog2(SIZE + 1);
  localparam int unsigned IW        = idx_w(SIZE);
  localparam int unsigned DRAIN_LEN = drain_len(SIZE);
  localparam int unsigned CW        = $clog2(DRAIN_LEN + 1);

  state_e        state, state_next;
  logic [NW-1:0] n_q;
  logic [CW-1:0] cnt;
  logic          n_ok, clr, beat, xfer, last_beat, drain_end;
  logic [IW-1:0] row_nx, col_nx;
  logic          last_nx;

  logic signed [DATA_WIDTH-1:0] a_lane [SIZE];
  logic signed [DATA_WIDTH-1:0] b_lane [SIZE];
  logic signed [DATA_WIDTH-1:0] a_sk   [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] b_sk   [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] a_w    [SIZE][SIZE+1];
  logic signed [DATA_WIDTH-1:0] b_w    [SIZE+1][SIZE];
  logic signed [ACC_WIDTH-1:0]  acc_w  [SIZE][SIZE];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    n_ok       = (n != '0) && (n <= NW'(SIZE));
    beat       = in_valid && in_ready;
    xfer       = out_valid && out_ready;
    clr        = (state == S_IDLE) && start && n_ok;
    last_beat  = beat && (cnt == (CW'(n_q) - CW'(1)));
    drain_end  = (cnt == CW'(DRAIN_LEN - 1));
    case (state)
      S_IDLE:  if (clr)              state_next = S_LOAD;
      S_LOAD:  if (last_beat)        state_next = S_DRAIN;
      S_DRAIN: if (drain_end)        state_next = S_OUT;
      S_OUT:   if (xfer && c_last)   state_next = S_IDLE;
      default:                       state_next = S_IDLE;
    endcase
  end

  // Row-major successor of the element currently presented.
  always_comb begin
    row_nx = c_row;
    col_nx = c_col + IW'(1);
    if (NW'(c_col) == (n_q - NW'(1))) begin
      col_nx = '0;
      row_nx = c_row + IW'(1);
    end
    last_nx = (NW'(row_nx) == (n_q - NW'(1))) && (NW'(col_nx) == (n_q - NW'(1)));
  end

  // Edge lanes: zero on bubbles and for lanes beyond the active dimension.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    assign a_lane[i] = (beat && (NW'(i) < n_q)) ? a_col_line[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_lane[i] = (beat && (NW'(i) < n_q)) ? b_row_line[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_w[0][0] = a_lane[0];
      assign b_w[0][0] = b_lane[0];
    end else begin : g_skewed
      assign a_w[i][0] = a_sk[i][i-1];
      assign b_w[0][i] = b_sk[i][i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      for (int d = 0; d < SIZE; d++) begin
        if (rst || clr) begin
          a_sk[i][d] <= '0;
          b_sk[i][d] <= '0;
        end else if (d == 0) begin
          a_sk[i][d] <= a_lane[i];
          b_sk[i][d] <= b_lane[i];
        end else begin
          a_sk[i][d] <= a_sk[i][d-1];
          b_sk[i][d] <= b_sk[i][d-1];
        end
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      pe_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .a_in  (a_w[i][j]),
        .b_in  (b_w[i][j]),
        .a_out (a_w[i][j+1]),
        .b_out (b_w[i+1][j]),
        .acc   (acc_w[i][j])
      );
    end
  end

  // Registered control outputs, beat/drain counter and result presentation.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      c_last    <= 1'b0;
      c_data    <= '0;
      c_row     <= '0;
      c_col     <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= (state_next != S_IDLE);
      in_ready <= (state_next == S_LOAD);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            if (n_ok) n_q <= n;
            else      err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (beat) cnt <= last_beat ? '0 : cnt + CW'(1);
        end
        S_DRAIN: begin
          cnt <= cnt + CW'(1);
          if (drain_end) begin
            out_valid <= 1'b1;
            c_row     <= '0;
            c_col     <= '0;
            c_data    <= acc_w[0][0];
            c_last    <= (n_q == NW'(1));
          end
        end
        S_OUT: begin
          if (xfer) begin
            if (c_last) begin
              out_valid <= 1'b0;
              c_last    <= 1'b0;
              done      <= 1'b1;
              c_data    <= '0;
              c_row     <= '0;
              c_col     <= '0;
            end else begin
              c_row  <= row_nx;
              c_col  <= col_nx;
              c_data <= acc_w[row_nx][col_nx];
              c_last <= last_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
